// File: rtl/filter_step_sequencer.sv
// Stimulus sequencer for the fixed-point filter: flushes the filter, steps in_val
// through a programmed level/dwell table, and flags |out_val| exceeding a limit.
module filter_step_sequencer #(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned NUM_STEPS = 4,
  parameter int unsigned DWELL_W   = 16,
  parameter int unsigned FLUSH_CYC = 4,
  localparam int unsigned SW       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_we,
  input  logic [SW-1:0]      cfg_addr,
  input  logic [WIDTH-1:0]   cfg_level,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [SW:0]        cfg_len,
  input  logic [WIDTH-1:0]   limit,
  input  logic [WIDTH-1:0]   out_val,
  output logic [WIDTH-1:0]   in_val,
  output logic               filt_rst,
  output logic               busy,
  output logic               done,
  output logic [SW-1:0]      step_idx,
  output logic               range_err,
  output logic [SW-1:0]      err_step
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   lvl_tab [NUM_STEPS];
  logic [DWELL_W-1:0] dwl_tab [NUM_STEPS];

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SW:0]        len_q, len_d;
  logic [WIDTH-1:0]   in_val_d;
  logic               filt_rst_d;
  logic               done_d;
  logic [SW-1:0]      step_idx_d;
  logic               range_err_d;
  logic [SW-1:0]      err_step_d;

  logic               tab_we_c;
  logic [SW:0]        len_clamp_c;
  logic [WIDTH:0]     out_ext_c;
  logic [WIDTH:0]     out_mag_c;
  logic               over_c;
  logic [SW-1:0]      step_nxt_c;
  logic               last_step_c;

  // Dwell of 0 behaves as 1: the counter counts down to zero inclusive.
  function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  // Table is writable only while idle; contents are deliberately not reset.
  assign tab_we_c = cfg_we && (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (tab_we_c) begin
      lvl_tab[cfg_addr] <= cfg_level;
      dwl_tab[cfg_addr] <= cfg_dwell;
    end
  end

  always_comb begin
    if (cfg_len == '0) begin
      len_clamp_c = (SW+1)'(1);
    end else if (cfg_len > (SW+1)'(NUM_STEPS)) begin
      len_clamp_c = (SW+1)'(NUM_STEPS);
    end else begin
      len_clamp_c = cfg_len;
    end
  end

  // Magnitude in WIDTH+1 bits so the most negative input maps to 2^(WIDTH-1).
  assign out_ext_c   = {out_val[WIDTH-1], out_val};
  assign out_mag_c   = out_val[WIDTH-1] ? (~out_ext_c + (WIDTH+1)'(1)) : out_ext_c;
  assign over_c      = out_mag_c > {1'b0, limit};

  assign step_nxt_c  = step_idx + SW'(1);
  assign last_step_c = ({1'b0, step_idx} == (len_q - (SW+1)'(1)));

  assign busy = (state_q == S_FLUSH) || (state_q == S_RUN);

  // Next-state and registered-output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    in_val_d    = in_val;
    filt_rst_d  = filt_rst;
    done_d      = 1'b0;
    step_idx_d  = step_idx;
    range_err_d = range_err;
    err_step_d  = err_step;

    if (abort) begin
      state_d    = S_IDLE;
      in_val_d   = '0;
      filt_rst_d = 1'b0;
      cnt_d      = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          in_val_d   = '0;
          filt_rst_d = 1'b0;
          if (start) begin
            state_d     = S_FLUSH;
            len_d       = len_clamp_c;
            range_err_d = 1'b0;
            err_step_d  = '0;
            step_idx_d  = '0;
            filt_rst_d  = 1'b1;
            cnt_d       = DWELL_W'(FLUSH_CYC - 1);
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            state_d    = S_RUN;
            filt_rst_d = 1'b0;
            in_val_d   = lvl_tab[SW'(0)];
            cnt_d      = dwell_load(dwl_tab[SW'(0)]);
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        S_RUN: begin
          if (over_c && !range_err) begin
            range_err_d = 1'b1;
            err_step_d  = step_idx;
          end
          if (cnt_q == '0) begin
            if (last_step_c) begin
              state_d  = S_IDLE;
              done_d   = 1'b1;
              in_val_d = '0;
            end else begin
              step_idx_d = step_nxt_c;
              in_val_d   = lvl_tab[step_nxt_c];
              cnt_d      = dwell_load(dwl_tab[step_nxt_c]);
            end
          end else begin
            cnt_d = cnt_q - DWELL_W'(1);
          end
        end
        default: begin
          state_d    = S_IDLE;
          in_val_d   = '0;
          filt_rst_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= (SW+1)'(1);
      in_val    <= '0;
      filt_rst  <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
      range_err <= 1'b0;
      err_step  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      in_val    <= in_val_d;
      filt_rst  <= filt_rst_d;
      done      <= done_d;
      step_idx  <= step_idx_d;
      range_err <= range_err_d;
      err_step  <= err_step_d;
    end
  end

endmodule
